arb_rr_2_to_1: RTL and testbench
================================

// Module: arb_rr_2_to_1
// PURPOSE
//   Two-source round-robin arbiter with a burst-hold option and a registered output slice.
//   Each source has its own valid/ready handshake.
//   Sits directly upstream of the 2:1 data mux path. It picks one source per beat and drives the
//   1-bit select key (o_key) together with the captured payload into a single downstream handshake.
//   Intended use is merging two request streams, e.g. instruction fetch and data access onto one
//   memory port.
// PARAMETERS
//   DATA_WIDTH  32  payload width of each source and of the output
//   BURST_LEN   1   max consecutive beats granted to one source while the other waits;
//                   1 = pure alternate, must be >= 1
// PORTS
//   i_clk      in   1           clock, all state on rising edge
//   i_rst      in   1           reset, asynchronous, active-high
//   i_valid_a  in   1           source A beat valid
//   i_data_a   in   DATA_WIDTH  source A payload
//   o_ready_a  out  1           source A beat accepted this cycle
//   i_valid_b  in   1           source B beat valid
//   i_data_b   in   DATA_WIDTH  source B payload
//   o_ready_b  out  1           source B beat accepted this cycle
//   o_valid    out  1           output slice holds a beat
//   o_data     out  DATA_WIDTH  payload of held beat
//   o_key      out  1           source of held beat: 0 = A, 1 = B
//   i_ready    in   1           downstream accepts held beat
// BEHAVIOUR
//   - Reset values: o_valid=0, o_data=0, o_key=0, owner=1 (B), cnt=BURST_LEN.
//     Result: A wins the first contention.
//   - Load enable: load = ~o_valid | i_ready. This gives full throughput of one beat per cycle
//     with no bubble.
//   - Grant, combinational:
//     - Only A valid -> A.
//     - Only B valid -> B.
//     - Both valid and cnt < BURST_LEN -> owner.
//     - Both valid and cnt == BURST_LEN -> ~owner.
//   - o_ready_x = load & grant_x. At most one of o_ready_a / o_ready_b is high.
//     Neither is high when no source is valid.
//   - Ready depends on i_ready combinationally. Valid never depends on ready.
//   - Accepted beat (valid & ready on source s), at the next edge:
//     - o_data <= i_data_s, o_key <= s, o_valid <= 1.
//     - If s == owner: cnt <= min(cnt+1, BURST_LEN).
//     - Else: owner <= s, cnt <= 1.
//   - If load and no source valid: o_valid <= 0. o_data and o_key hold their last values.
//   - Stall (o_valid & ~i_ready): o_data, o_key, o_valid are stable. owner and cnt are unchanged.
//   - Latency: accepted beat appears on o_valid exactly 1 cycle later.
//   - A lone source is never blocked by the burst limit. cnt saturates and does not wrap.
//   - Reset mid-transfer: the held beat is dropped (o_valid=0 asynchronously) and the
//     arbitration state returns to reset values.
//   - Source rule: once asserted, a source valid is held until its ready (not checked).
// STRUCTURE
//   - Shared package holds typedef arb_src_e {SRC_A=1'b0, SRC_B=1'b1}.
//     o_key and owner use this type.
//   - Payload select uses the existing mux_2_to_1 sub-module instance: key = grant_b,
//     val_a = i_data_a, val_b = i_data_b.
//   - Grant logic and the output slice stay in this module.
//   - cnt width: $clog2(BURST_LEN+1).
// TESTING
//   1. Reset, then A=0x11 alone with i_ready=1 -> next cycle o_valid=1, o_data=0x11, o_key=0.
//      o_ready_b never high.
//   2. BURST_LEN=1, both valid every cycle (A=0xA0.., B=0xB0..), i_ready=1
//      -> o_key sequence 0,1,0,1 with one beat per cycle.
//   3. BURST_LEN=3, both valid continuously -> o_key sequence 0,0,0,1,1,1,0.
//      B alone for 5 beats -> 5 consecutive B beats, no stall.
//   4. Hold o_valid=1 with i_ready=0 for 4 cycles while A and B are valid
//      -> o_ready_a = o_ready_b = 0; o_data/o_key stable. Release -> pending grant proceeds
//      the same cycle.
//   5. Assert i_rst mid-stream with o_valid=1 -> o_valid=0 immediately (asynchronous).
//      After release, first contention goes to A.
//   6. Random valids and i_ready against a scoreboard -> no beat lost or duplicated.
//      o_ready_a & o_ready_b is never 1. With BURST_LEN=2, the waiting source gets a grant
//      within 2 accepted beats.

Source files
------------

// File: rtl/arb_rr_2_to_1_pkg.sv
// Shared types for the two-source round-robin arbiter.
//   arb_src_e : source identifier, used for the output key and the burst owner.
//   other_src : returns the opposite source.
package arb_rr_2_to_1_pkg;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } arb_src_e;

    function automatic arb_src_e other_src(input arb_src_e s);
        return (s == SRC_A) ? SRC_B : SRC_A;
    endfunction

endpackage

// File: rtl/arb_rr_2_to_1_if.sv
// Handshake bundle for arb_rr_2_to_1: two upstream sources and one downstream slice.
//   i_valid_a/i_data_a/o_ready_a : source A beat
//   i_valid_b/i_data_b/o_ready_b : source B beat
//   o_valid/o_data/o_key/i_ready : downstream beat, o_key names its source
// Signal prefixes are from the arbiter's point of view.
//   slave  : the arbiter
//   master : the environment (sources and sink)
interface arb_rr_2_to_1_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    import arb_rr_2_to_1_pkg::*;

    logic                  i_valid_a;
    logic [DATA_WIDTH-1:0] i_data_a;
    logic                  o_ready_a;
    logic                  i_valid_b;
    logic [DATA_WIDTH-1:0] i_data_b;
    logic                  o_ready_b;
    logic                  o_valid;
    logic [DATA_WIDTH-1:0] o_data;
    arb_src_e              o_key;
    logic                  i_ready;

    modport slave (
        input  i_valid_a, i_data_a, i_valid_b, i_data_b, i_ready,
        output o_ready_a, o_ready_b, o_valid, o_data, o_key
    );

    modport master (
        output i_valid_a, i_data_a, i_valid_b, i_data_b, i_ready,
        input  o_ready_a, o_ready_b, o_valid, o_data, o_key
    );

endinterface

// File: rtl/mux_2_to_1.sv
// Two-input payload multiplexer.
//   key_i   : 0 selects val_a_i, 1 selects val_b_i
//   val_a_i : input A
//   val_b_i : input B
//   val_o   : selected value
module mux_2_to_1 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             key_i,
    input  logic [WIDTH-1:0] val_a_i,
    input  logic [WIDTH-1:0] val_b_i,
    output logic [WIDTH-1:0] val_o
);

    assign val_o = key_i ? val_b_i : val_a_i;

endmodule

// File: rtl/arb_rr_2_to_1.sv
// Two-source round-robin arbiter with burst hold and a registered output slice.
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : arb_rr_2_to_1_if.slave (two source handshakes, one downstream handshake)
// A source may keep the grant for up to BURST_LEN consecutive beats while the other
// waits; a lone valid source is always granted. One beat per cycle, one cycle latency.
module arb_rr_2_to_1
    import arb_rr_2_to_1_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 1
) (
    input logic            i_clk,
    input logic            i_rst,
    arb_rr_2_to_1_if.slave bus
);

    localparam int unsigned CntW = $clog2(BURST_LEN + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(BURST_LEN);

    arb_src_e              owner_q, owner_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    arb_src_e              key_q, key_d;

    logic                  load;
    logic                  burst_done;
    logic                  grant_a;
    logic                  grant_b;
    logic                  accept;
    arb_src_e              acc_src;
    arb_src_e              winner;
    logic [DATA_WIDTH-1:0] sel_data;

    // Slice can take a new beat when empty or when its beat leaves this cycle.
    assign load       = ~valid_q | bus.i_ready;
    assign burst_done = (cnt_q == CntMax);

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        winner  = owner_q;
        unique case ({bus.i_valid_a, bus.i_valid_b})
            2'b10: grant_a = 1'b1;
            2'b01: grant_b = 1'b1;
            2'b11: begin
                // Owner keeps the grant until its burst quota is used up.
                winner  = burst_done ? other_src(owner_q) : owner_q;
                grant_b = (winner == SRC_B);
                grant_a = (winner == SRC_A);
            end
            default: ;
        endcase
    end

    assign bus.o_ready_a = load & grant_a;
    assign bus.o_ready_b = load & grant_b;
    assign accept        = bus.o_ready_a | bus.o_ready_b;
    assign acc_src       = grant_b ? SRC_B : SRC_A;

    mux_2_to_1 #(
        .WIDTH (DATA_WIDTH)
    ) u_mux (
        .key_i   (grant_b),
        .val_a_i (bus.i_data_a),
        .val_b_i (bus.i_data_b),
        .val_o   (sel_data)
    );

    always_comb begin
        owner_d = owner_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        key_d   = key_q;
        if (load) begin
            if (accept) begin
                valid_d = 1'b1;
                data_d  = sel_data;
                key_d   = acc_src;
                if (acc_src == owner_q) begin
                    // Saturate so a lone source never wraps back into a fresh quota.
                    if (!burst_done) begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end else begin
                    owner_d = acc_src;
                    cnt_d   = CntW'(1);
                end
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    // Owner B with a spent quota means A wins the first contention after reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            owner_q <= SRC_B;
            cnt_q   <= CntMax;
            valid_q <= 1'b0;
            data_q  <= '0;
            key_q   <= SRC_A;
        end else begin
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            key_q   <= key_d;
        end
    end

    assign bus.o_valid = valid_q;
    assign bus.o_data  = data_q;
    assign bus.o_key   = key_q;

endmodule

// File: tb/tb_arb_rr_2_to_1.sv
// Self-checking bench for arb_rr_2_to_1: three instances with BURST_LEN 1, 2 and 3.
module tb_arb_rr_2_to_1;
    import arb_rr_2_to_1_pkg::*;

    localparam int NDUT = 3;
    localparam int DW   = 32;
    localparam int SB   = 1;  // instance with BURST_LEN=2 carries the scoreboard

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          va  [NDUT];
    logic          vb  [NDUT];
    logic          rdy [NDUT];
    logic [DW-1:0] da  [NDUT];
    logic [DW-1:0] db  [NDUT];
    logic          ra  [NDUT];
    logic          rb  [NDUT];
    logic          ov  [NDUT];
    logic [DW-1:0] od  [NDUT];
    logic          ok  [NDUT];

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        arb_rr_2_to_1_if #(.DATA_WIDTH(DW)) bus ();
        arb_rr_2_to_1 #(
            .DATA_WIDTH (DW),
            .BURST_LEN  (k + 1)
        ) u_dut (
            .i_clk (clk),
            .i_rst (rst),
            .bus   (bus.slave)
        );
        assign bus.i_valid_a = va[k];
        assign bus.i_data_a  = da[k];
        assign bus.i_valid_b = vb[k];
        assign bus.i_data_b  = db[k];
        assign bus.i_ready   = rdy[k];
        assign ra[k] = bus.o_ready_a;
        assign rb[k] = bus.o_ready_b;
        assign ov[k] = bus.o_valid;
        assign od[k] = bus.o_data;
        assign ok[k] = bus.o_key;
    end

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          key;
    } beat_t;
    beat_t sb_q[$];
    int    n_pushed = 0;
    int    n_popped = 0;
    logic  acc_a, acc_b;
    logic  run_src;
    int    run_len;

    typedef struct packed {
        logic       va;
        logic       vb;
        logic       ev;
        logic [2:0] ek;  // expected key, bit k for instance k
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_all(input logic a, input logic b, input logic [DW-1:0] dat_a,
                             input logic [DW-1:0] dat_b, input logic r);
        for (int k = 0; k < NDUT; k++) begin
            va[k] = a; vb[k] = b; da[k] = dat_a; db[k] = dat_b; rdy[k] = r;
        end
    endtask

    task automatic flush_sb();
        sb_q.delete();
        run_src = 1'b1;
        run_len = 0;
    endtask

    task automatic note_accept(input logic s, input logic other_valid);
        if (s != run_src) begin
            run_src = s;
            run_len = 0;
        end
        if (other_valid) begin
            run_len++;
            check("fair_wait", 64'(run_len <= 2), 64'd1);
        end
    endtask

    // Per-cycle monitor, called at the falling edge.
    task automatic mon();
        beat_t b;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("ready_excl[%0d]", k),
                  {61'd0, ra[k] & rb[k], ra[k] & ~va[k], rb[k] & ~vb[k]}, 64'd0);
        end
        if (ov[SB] && rdy[SB]) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_beat", {31'd0, ok[SB], od[SB]}, 64'd0);
            end else begin
                b = sb_q.pop_front();
                n_popped++;
                check("sb_beat", {31'd0, ok[SB], od[SB]}, {31'd0, b.key, b.data});
            end
        end
        acc_a = ra[SB] & va[SB];
        acc_b = rb[SB] & vb[SB];
        if (acc_a) begin
            b.data = da[SB]; b.key = 1'b0;
            sb_q.push_back(b); n_pushed++;
            note_accept(1'b0, vb[SB]);
        end
        if (acc_b) begin
            b.data = db[SB]; b.key = 1'b1;
            sb_q.push_back(b); n_pushed++;
            note_accept(1'b1, va[SB]);
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
        mon();
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_all(1'b0, 1'b0, '0, '0, 1'b0);
        flush_sb();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("reset_state[%0d]", k), {31'd0, ov[k], ok[k], od[k]}, 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tbl[14];
        logic [DW-1:0] exp_d[NDUT];
        logic [DW-1:0] cur_a, cur_b;
        logic          ek;
        logic [2:0]    exp_gb;
        int unsigned   seq_a, seq_b;

        flush_sb();
        acc_a = 1'b0;
        acc_b = 1'b0;

        // Contention then lone B then idle then lone A; rdy held high.
        tbl[0]  = '{va: 1, vb: 1, ev: 1, ek: 3'b000};
        tbl[1]  = '{va: 1, vb: 1, ev: 1, ek: 3'b001};
        tbl[2]  = '{va: 1, vb: 1, ev: 1, ek: 3'b010};
        tbl[3]  = '{va: 1, vb: 1, ev: 1, ek: 3'b111};
        tbl[4]  = '{va: 1, vb: 1, ev: 1, ek: 3'b100};
        tbl[5]  = '{va: 1, vb: 1, ev: 1, ek: 3'b101};
        tbl[6]  = '{va: 1, vb: 1, ev: 1, ek: 3'b010};
        for (int i = 7; i < 12; i++) tbl[i] = '{va: 0, vb: 1, ev: 1, ek: 3'b111};
        tbl[12] = '{va: 0, vb: 0, ev: 0, ek: 3'b111};
        tbl[13] = '{va: 1, vb: 0, ev: 1, ek: 3'b000};

        // Lone A after reset.
        do_reset();
        drive_all(1'b1, 1'b0, 32'h11, 32'h0, 1'b1);
        to_neg();
        for (int k = 0; k < NDUT; k++)
            check($sformatf("lone_a_ready[%0d]", k), {62'd0, ra[k], rb[k]}, 64'd2);
        to_pos();
        drive_all(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        for (int k = 0; k < NDUT; k++)
            check($sformatf("lone_a_out[%0d]", k), {31'd0, ov[k], ok[k], od[k]},
                  {31'd0, 1'b1, 1'b0, 32'h11});
        to_neg();
        to_pos();
        for (int k = 0; k < NDUT; k++)
            check($sformatf("idle_hold[%0d]", k), {31'd0, ov[k], ok[k], od[k]},
                  {31'd0, 1'b0, 1'b0, 32'h11});

        // Table-driven contention and burst sequences.
        do_reset();
        for (int k = 0; k < NDUT; k++) exp_d[k] = '0;
        for (int i = 0; i < 14; i++) begin
            cur_a = 32'hA0 + 32'(i);
            cur_b = 32'hB0 + 32'(i);
            drive_all(tbl[i].va, tbl[i].vb, cur_a, cur_b, 1'b1);
            to_neg();
            for (int k = 0; k < NDUT; k++) begin
                ek = tbl[i].ek[k];
                check($sformatf("vec%0d_ready[%0d]", i, k), {62'd0, ra[k], rb[k]},
                      {62'd0, tbl[i].ev & ~ek, tbl[i].ev & ek});
            end
            to_pos();
            for (int k = 0; k < NDUT; k++) begin
                ek = tbl[i].ek[k];
                if (tbl[i].ev) exp_d[k] = ek ? cur_b : cur_a;
                check($sformatf("vec%0d_out[%0d]", i, k), {31'd0, ov[k], ok[k], od[k]},
                      {31'd0, tbl[i].ev, ek, exp_d[k]});
            end
        end

        // Stall with both sources pending, then release.
        do_reset();
        drive_all(1'b1, 1'b0, 32'h55, 32'h0, 1'b1);
        to_neg();
        to_pos();
        drive_all(1'b1, 1'b1, 32'h66, 32'h77, 1'b0);
        for (int c = 0; c < 4; c++) begin
            to_neg();
            for (int k = 0; k < NDUT; k++)
                check($sformatf("stall%0d[%0d]", c, k),
                      {29'd0, ra[k], rb[k], ov[k], ok[k], od[k]},
                      {29'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h55});
            to_pos();
        end
        exp_gb = 3'b001;  // after one A beat only BURST_LEN=1 hands over to B
        for (int k = 0; k < NDUT; k++) rdy[k] = 1'b1;
        to_neg();
        for (int k = 0; k < NDUT; k++)
            check($sformatf("release_ready[%0d]", k), {62'd0, ra[k], rb[k]},
                  {62'd0, ~exp_gb[k], exp_gb[k]});
        to_pos();
        for (int k = 0; k < NDUT; k++)
            check($sformatf("release_out[%0d]", k), {31'd0, ov[k], ok[k], od[k]},
                  {31'd0, 1'b1, exp_gb[k], exp_gb[k] ? 32'h77 : 32'h66});

        // Asynchronous reset while a beat is held.
        do_reset();
        drive_all(1'b1, 1'b0, 32'h21, 32'h0, 1'b1);
        to_neg();
        to_pos();
        #2;
        rst = 1'b1;
        flush_sb();
        #1;
        for (int k = 0; k < NDUT; k++)
            check($sformatf("async_rst[%0d]", k), {31'd0, ov[k], ok[k], od[k]}, 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        drive_all(1'b1, 1'b1, 32'h31, 32'h41, 1'b1);
        to_neg();
        for (int k = 0; k < NDUT; k++)
            check($sformatf("post_rst_ready[%0d]", k), {62'd0, ra[k], rb[k]}, 64'd2);
        to_pos();
        for (int k = 0; k < NDUT; k++)
            check($sformatf("post_rst_out[%0d]", k), {31'd0, ov[k], ok[k], od[k]},
                  {31'd0, 1'b1, 1'b0, 32'h31});

        // Random traffic on the BURST_LEN=2 instance against the scoreboard.
        do_reset();
        n_pushed = 0;
        n_popped = 0;
        for (int k = 0; k < NDUT; k++) rdy[k] = 1'b1;
        seq_a = 0;
        seq_b = 0;
        acc_a = 1'b0;
        acc_b = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if (!va[SB] || acc_a) begin
                va[SB] = ($urandom_range(0, 3) != 0);
                da[SB] = 32'hA000_0000 | 32'(seq_a);
                seq_a++;
            end
            if (!vb[SB] || acc_b) begin
                vb[SB] = ($urandom_range(0, 3) != 0);
                db[SB] = 32'hB000_0000 | 32'(seq_b);
                seq_b++;
            end
            rdy[SB] = ($urandom_range(0, 3) != 0);
            to_neg();
            to_pos();
        end
        va[SB] = 1'b0;
        vb[SB] = 1'b0;
        rdy[SB] = 1'b1;
        repeat (3) begin
            to_neg();
            to_pos();
        end
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        check("sb_counts", 64'(n_popped), 64'(n_pushed));
        check("sb_activity", 64'(n_pushed > 200), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
